// File: rtl/frame_pkg.sv
// Shared frame-format definitions for the frame encoder and its companion decoder.
package frame_pkg;

  localparam logic [7:0] FRAME_HDR        = 8'hC9;
  localparam logic [7:0] FRAME_TYPE_SHORT = 8'h60;
  localparam logic [7:0] FRAME_TYPE_LONG  = 8'h61;
  localparam logic [7:0] FRAME_TRAIL      = 8'h9C;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_TYPE,
    ST_ADDR,
    ST_DATA0,
    ST_DATA1,
    ST_TRAIL
  } frame_state_e;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data0;
    logic [7:0] data1;
    logic       is_long;
  } frame_req_t;

  function automatic logic [7:0] frame_type(input logic is_long);
    return is_long ? FRAME_TYPE_LONG : FRAME_TYPE_SHORT;
  endfunction

endpackage

// File: rtl/frame_req_fifo.sv
// Parameterised synchronous request FIFO; combinational read of the head entry.
module frame_req_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 25
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + PW'(1);
    if (do_pop)  rd_d = rd_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/frame_encoder.sv
// Serialises write requests into C9/type/addr/data/9C byte frames.
// Define FRAME_ENC_FIFO_EN to replace the single holding register with a FIFO.
module frame_encoder
  import frame_pkg::*;
#(
  parameter logic [7:0] IDLE_WORD  = 8'h00,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_data0,
  input  logic [7:0] req_data1,
  input  logic       req_long,
  output logic [7:0] word_out,
  output logic       word_valid,
  output logic       frame_done,
  output logic       busy
);

  frame_state_e state_q;
  frame_req_t   frame_q;
  frame_req_t   req_in, head;
  logic [7:0]   word_out_q;
  logic         word_valid_q, frame_done_q;
  logic         buf_nonempty, push, pop;

  assign req_in = '{addr: req_addr, data0: req_data0, data1: req_data1, is_long: req_long};
  assign push   = req_valid && req_ready;
  assign pop    = buf_nonempty && ((state_q == ST_IDLE) || (state_q == ST_TRAIL));

`ifdef FRAME_ENC_FIFO_EN
  logic fifo_empty, fifo_full;

  frame_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(frame_req_t))
  ) u_req_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (req_in),
    .dout  (head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign buf_nonempty = !fifo_empty;
  assign req_ready    = !reset && !fifo_full;
`else
  frame_req_t hold_q, hold_d;
  logic       hold_vld_q, hold_vld_d;
  logic       unused_depth;

  assign unused_depth = (FIFO_DEPTH > 0);

  // A push only happens when empty and a pop only when full, so they never collide.
  always_comb begin
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    if (pop) hold_vld_d = 1'b0;
    if (push) begin
      hold_d     = req_in;
      hold_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) hold_vld_q <= 1'b0;
    else       hold_vld_q <= hold_vld_d;
    hold_q <= hold_d;
  end

  assign head         = hold_q;
  assign buf_nonempty = hold_vld_q;
  assign req_ready    = !reset && !hold_vld_q;
`endif

  assign busy = (state_q != ST_IDLE) || buf_nonempty;

  // Each state's byte is loaded on the edge that enters it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      word_out_q   <= IDLE_WORD;
      word_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_TRAIL: begin
          if (buf_nonempty) begin
            state_q      <= ST_HDR;
            frame_q      <= head;
            word_out_q   <= FRAME_HDR;
            word_valid_q <= 1'b1;
          end else begin
            state_q      <= ST_IDLE;
            word_out_q   <= IDLE_WORD;
            word_valid_q <= 1'b0;
          end
        end
        ST_HDR: begin
          state_q    <= ST_TYPE;
          word_out_q <= frame_type(frame_q.is_long);
        end
        ST_TYPE: begin
          state_q    <= ST_ADDR;
          word_out_q <= frame_q.addr;
        end
        ST_ADDR: begin
          state_q    <= ST_DATA0;
          word_out_q <= frame_q.data0;
        end
        ST_DATA0: begin
          if (frame_q.is_long) begin
            state_q    <= ST_DATA1;
            word_out_q <= frame_q.data1;
          end else begin
            state_q      <= ST_TRAIL;
            word_out_q   <= FRAME_TRAIL;
            frame_done_q <= 1'b1;
          end
        end
        ST_DATA1: begin
          state_q      <= ST_TRAIL;
          word_out_q   <= FRAME_TRAIL;
          frame_done_q <= 1'b1;
        end
        default: begin
          state_q      <= ST_IDLE;
          word_out_q   <= IDLE_WORD;
          word_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign word_out   = word_out_q;
  assign word_valid = word_valid_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_frame_encoder.sv
// Self-checking bench for frame_encoder: transaction-level model plus directed frame checks.
module tb_frame_encoder;

  localparam logic [7:0] IDLE_W = 8'hE7;
`ifdef FRAME_ENC_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic       clk, reset;
  logic       req_valid, req_ready, req_long;
  logic [7:0] req_addr, req_data0, req_data1;
  logic [7:0] word_out;
  logic       word_valid, frame_done, busy;

  frame_encoder #(.IDLE_WORD(IDLE_W), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data0  (req_data0),
    .req_data1  (req_data1),
    .req_long   (req_long),
    .word_out   (word_out),
    .word_valid (word_valid),
    .frame_done (frame_done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit [7:0] a, d0, d1;
    bit       l;
  } mreq_t;

  mreq_t    pend[$];
  bit [7:0] fb[$];
  bit [7:0] seen[$];
  int       done_cnt = 0;
  int       vectors = 0;
  int       miscompares = 0;
  int       cyc = 0;
  int       first_v = -1;
  int       last_v = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: buffered requests wait in pend; the frame on the wire is the byte list fb.
  always @(posedge clk) begin
    bit    acc;
    mreq_t r, nr;
    acc = req_valid && !reset && (pend.size() < CAP);
    nr.a = req_addr; nr.d0 = req_data0; nr.d1 = req_data1; nr.l = req_long;
    if (reset) begin
      pend.delete();
      fb.delete();
    end else begin
      if (fb.size() > 1) begin
        void'(fb.pop_front());
      end else begin
        fb.delete();
        if (pend.size() > 0) begin
          r = pend.pop_front();
          fb.push_back(8'hC9);
          fb.push_back(r.l ? 8'h61 : 8'h60);
          fb.push_back(r.a);
          fb.push_back(r.d0);
          if (r.l) fb.push_back(r.d1);
          fb.push_back(8'h9C);
        end
      end
      if (acc) pend.push_back(nr);
    end
    #1;
    cyc++;
    chk("word_out", 32'(word_out), 32'((fb.size() > 0) ? fb[0] : IDLE_W));
    chk("word_valid", 32'(word_valid), 32'(fb.size() > 0));
    chk("frame_done", 32'(frame_done), 32'(fb.size() == 1));
    chk("busy", 32'(busy), 32'((fb.size() > 0) || (pend.size() > 0)));
    chk("req_ready", 32'(req_ready), 32'(!reset && (pend.size() < CAP)));
    if (word_valid === 1'b1) begin
      seen.push_back(word_out);
      if (first_v < 0) first_v = cyc;
      last_v = cyc;
    end
    if (frame_done === 1'b1) done_cnt++;
  end

  task automatic send(input bit [7:0] a, input bit [7:0] d0, input bit [7:0] d1,
                      input bit l, input bit hold);
    int n;
    req_addr = a; req_data0 = d0; req_data1 = d1; req_long = l; req_valid = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 32'(n < 50), 32'd1);
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("idle_timeout", 32'(n < 200), 32'd1);
  endtask

  function automatic bit [7:0] rbyte();
    if ($urandom_range(0, 3) == 0) begin
      case ($urandom_range(0, 3))
        0:       return 8'hC9;
        1:       return 8'h60;
        2:       return 8'h61;
        default: return 8'h9C;
      endcase
    end
    return 8'($urandom);
  endfunction

  initial begin
    bit [7:0] exp_s[5];
    bit [7:0] exp_l[6];
    bit [7:0] exp_a[5];
    int       d, n, total;

    reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_data0 = '0; req_data1 = '0;
    req_long = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_word_out", 32'(word_out), 32'(IDLE_W));
    chk("rst_word_valid", 32'(word_valid), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(req_ready), 32'd1);

    // Short frame with latency check
    exp_s = '{8'hC9, 8'h60, 8'h12, 8'h34, 8'h9C};
    seen.delete(); d = done_cnt;
    send(8'h12, 8'h34, 8'h00, 1'b0, 1'b0);
    chk("lat_gap", 32'(word_valid), 32'd0);
    @(negedge clk);
    chk("lat_hdr", 32'(word_out), 32'hC9);
    wait_idle();
    chk("short_len", 32'(seen.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < seen.size()) chk("short_byte", 32'(seen[i]), 32'(exp_s[i]));
    chk("short_done", 32'(done_cnt - d), 32'd1);

    // Long frame
    exp_l = '{8'hC9, 8'h61, 8'hA5, 8'h01, 8'h02, 8'h9C};
    seen.delete(); d = done_cnt;
    send(8'hA5, 8'h01, 8'h02, 1'b1, 1'b0);
    wait_idle();
    chk("long_len", 32'(seen.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      if (i < seen.size()) chk("long_byte", 32'(seen[i]), 32'(exp_l[i]));
    chk("long_done", 32'(done_cnt - d), 32'd1);

    // Back-to-back: short then long with valid held
    seen.delete(); d = done_cnt; first_v = -1;
    send(8'h12, 8'h34, 8'h00, 1'b0, 1'b1);
    send(8'hA5, 8'h01, 8'h02, 1'b1, 1'b0);
    wait_idle();
    chk("b2b_len", 32'(seen.size()), 32'd11);
    chk("b2b_span", 32'(last_v - first_v + 1), 32'd11);
    if (seen.size() == 11) begin
      chk("b2b_trail0", 32'(seen[4]), 32'h9C);
      chk("b2b_hdr1", 32'(seen[5]), 32'hC9);
      chk("b2b_type1", 32'(seen[6]), 32'h61);
    end
    chk("b2b_done", 32'(done_cnt - d), 32'd2);

    // Payload aliasing of header/trailer values
    exp_a = '{8'hC9, 8'h60, 8'h9C, 8'hC9, 8'h9C};
    seen.delete(); d = done_cnt;
    send(8'h9C, 8'hC9, 8'h00, 1'b0, 1'b0);
    wait_idle();
    chk("alias_len", 32'(seen.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < seen.size()) chk("alias_byte", 32'(seen[i]), 32'(exp_a[i]));
    chk("alias_done", 32'(done_cnt - d), 32'd1);

    // Reset while the address byte is on the wire
    seen.delete(); d = done_cnt;
    send(8'h77, 8'h55, 8'h00, 1'b0, 1'b0);
    n = 0;
    while (!(word_valid === 1'b1 && word_out === 8'h77) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("addr_timeout", 32'(n < 20), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_word_out", 32'(word_out), 32'(IDLE_W));
    chk("midrst_valid", 32'(word_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("midrst_len", 32'(seen.size()), 32'd3);
    chk("midrst_done", 32'(done_cnt - d), 32'd0);

    // Five requests pushed while output is active
    seen.delete(); d = done_cnt; total = 0;
    for (int k = 0; k < 5; k++) begin
      send(8'(8'h20 + k), 8'(8'h40 + k), 8'(8'h80 + k), k[0], (k != 4));
      total += k[0] ? 6 : 5;
    end
    wait_idle();
    chk("burst_done", 32'(done_cnt - d), 32'd5);
    chk("burst_len", 32'(seen.size()), 32'(total));

    // Randomised traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_addr  = rbyte();
      req_data0 = rbyte();
      req_data1 = rbyte();
      req_long  = 1'($urandom);
      reset     = ($urandom_range(0, 199) == 0);
      @(negedge clk);
    end
    reset = 1'b0; req_valid = 1'b0;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
